// File: rtl/serial_subtractor_pkg.sv
// Shared definitions for the bit-serial subtractor: default width and FSM states.
package serial_subtractor_pkg;

    localparam int DEFAULT_WIDTH = 8;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

endpackage

// File: rtl/full_subtractor_cell.sv
// One-bit full subtractor: d = x - y - br, with borrow-out.
module full_subtractor_cell (
    input  logic x,
    input  logic y,
    input  logic br,
    output logic d,
    output logic br_next
);

    assign d       = x ^ y ^ br;
    assign br_next = (~x & y) | (~(x ^ y) & br);

endmodule

// File: rtl/serial_subtractor.sv
// Bit-serial subtractor: computes a - b - bin one bit per enabled cycle, LSB first.
module serial_subtractor
    import serial_subtractor_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             ena,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             bin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] diff,
    output logic             bout,
    output logic             ovf
);

    localparam int            CW   = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    state_t           r_state;
    logic [WIDTH-1:0] r_a;
    logic [WIDTH-1:0] r_b;
    logic [WIDTH-1:0] r_shift;
    logic [WIDTH-1:0] r_diff;
    logic [CW-1:0]    r_cnt;
    logic             r_br;
    logic             r_busy;
    logic             r_done;
    logic             r_bout;
    logic             r_ovf;

    logic             w_x;
    logic             w_y;
    logic             w_d;
    logic             w_br_next;
    logic [WIDTH-1:0] w_shift_next;

    assign w_x          = r_a[r_cnt];
    assign w_y          = r_b[r_cnt];
    // New bit enters at the MSB; after WIDTH shifts bit i sits at position i.
    assign w_shift_next = {w_d, r_shift[WIDTH-1:1]};

    full_subtractor_cell u_cell (
        .x       (w_x),
        .y       (w_y),
        .br      (r_br),
        .d       (w_d),
        .br_next (w_br_next)
    );

    // Control FSM, datapath registers and registered outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
            r_a     <= '0;
            r_b     <= '0;
            r_shift <= '0;
            r_diff  <= '0;
            r_cnt   <= '0;
            r_br    <= 1'b0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
            r_bout  <= 1'b0;
            r_ovf   <= 1'b0;
        end else if (ena) begin
            case (r_state)
                IDLE: begin
                    r_done <= 1'b0;
                    if (start) begin
                        r_a     <= a;
                        r_b     <= b;
                        r_br    <= bin;
                        r_cnt   <= '0;
                        r_shift <= '0;
                        r_busy  <= 1'b1;
                        r_state <= BUSY;
                    end
                end
                BUSY: begin
                    r_shift <= w_shift_next;
                    r_br    <= w_br_next;
                    if (r_cnt == LAST) begin
                        r_cnt   <= '0;
                        r_busy  <= 1'b0;
                        r_done  <= 1'b1;
                        r_diff  <= w_shift_next;
                        r_bout  <= w_br_next;
                        r_ovf   <= (r_a[WIDTH-1] ^ r_b[WIDTH-1]) & (w_d ^ r_a[WIDTH-1]);
                        r_state <= DONE;
                    end else begin
                        r_cnt <= r_cnt + CW'(1);
                    end
                end
                DONE: begin
                    r_done  <= 1'b0;
                    r_state <= IDLE;
                end
                default: begin
                    r_busy  <= 1'b0;
                    r_done  <= 1'b0;
                    r_state <= IDLE;
                end
            endcase
        end
    end

    assign busy = r_busy;
    assign done = r_done;
    assign diff = r_diff;
    assign bout = r_bout;
    assign ovf  = r_ovf;

endmodule

// File: tb/tb_serial_subtractor.sv
// Self-checking bench for serial_subtractor against an arithmetic reference model.
module tb_serial_subtractor;

    localparam int W   = 8;
    localparam int TMO = 64;

    logic         clk;
    logic         rst;
    logic         ena;
    logic         start;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         bin;
    logic         busy;
    logic         done;
    logic [W-1:0] diff;
    logic         bout;
    logic         ovf;

    int errors = 0;
    int checks = 0;

    serial_subtractor #(.WIDTH(W)) dut (
        .clk   (clk),
        .rst   (rst),
        .ena   (ena),
        .start (start),
        .a     (a),
        .b     (b),
        .bin   (bin),
        .busy  (busy),
        .done  (done),
        .diff  (diff),
        .bout  (bout),
        .ovf   (ovf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference: unsigned difference with borrow, and signed range check for overflow.
    function automatic logic [W-1:0] ref_diff(input logic [W-1:0] x, input logic [W-1:0] y, input logic c);
        int r;
        r = int'(x) - int'(y) - int'(c);
        if (r < 0) r = r + (1 << W);
        return W'(r);
    endfunction

    function automatic logic ref_bout(input logic [W-1:0] x, input logic [W-1:0] y, input logic c);
        return (int'(x) - int'(y) - int'(c)) < 0;
    endfunction

    function automatic logic ref_ovf(input logic [W-1:0] x, input logic [W-1:0] y, input logic c);
        int sx, sy, r;
        sx = (int'(x) >= (1 << (W - 1))) ? int'(x) - (1 << W) : int'(x);
        sy = (int'(y) >= (1 << (W - 1))) ? int'(y) - (1 << W) : int'(y);
        r  = sx - sy - int'(c);
        return (r < -(1 << (W - 1))) || (r > (1 << (W - 1)) - 1);
    endfunction

    // Issue one operation from IDLE (called 1ns after a rising edge) and wait for done.
    task automatic do_op(input logic [W-1:0] xa, input logic [W-1:0] xb, input logic xc,
                         output int lat, output logic [W-1:0] od, output logic ob, output logic oo,
                         output logic done_after, output logic [W-1:0] d_after);
        start = 1'b1; a = xa; b = xb; bin = xc;
        @(posedge clk); #1;
        start = 1'b0;
        lat = 1;
        while (done !== 1'b1 && lat < TMO) begin
            @(posedge clk); #1;
            lat++;
        end
        od = diff; ob = bout; oo = ovf;
        @(posedge clk); #1;
        done_after = done;
        d_after    = diff;
    endtask

    task automatic test_reset();
        rst = 1'b1; ena = 1'b1; start = 1'b1; a = 8'hAA; b = 8'h11; bin = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0; start = 1'b0;
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got=%b exp=0", busy); end
        checks++; if (done !== 1'b0) begin errors++; $display("FAIL reset_done got=%b exp=0", done); end
        checks++; if (diff !== '0) begin errors++; $display("FAIL reset_diff got=%h exp=00", diff); end
        checks++; if (bout !== 1'b0) begin errors++; $display("FAIL reset_bout got=%b exp=0", bout); end
        checks++; if (ovf !== 1'b0) begin errors++; $display("FAIL reset_ovf got=%b exp=0", ovf); end
        @(posedge clk); #1;
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_priority_busy got=%b exp=0", busy); end
    endtask

    task automatic test_directed();
        logic [W-1:0] va [4] = '{8'h05, 8'h03, 8'h00, 8'h80};
        logic [W-1:0] vb [4] = '{8'h03, 8'h05, 8'h00, 8'h01};
        logic         vc [4] = '{1'b0, 1'b0, 1'b1, 1'b0};
        logic [W-1:0] ed [4] = '{8'h02, 8'hFE, 8'hFF, 8'h7F};
        logic         eb [4] = '{1'b0, 1'b1, 1'b1, 1'b0};
        logic         eo [4] = '{1'b0, 1'b0, 1'b0, 1'b1};
        int lat; logic [W-1:0] od, da; logic ob, oo, dn;
        for (int i = 0; i < 4; i++) begin
            do_op(va[i], vb[i], vc[i], lat, od, ob, oo, dn, da);
            checks++; if (lat !== W + 1) begin errors++; $display("FAIL dir%0d_latency got=%0d exp=%0d", i, lat, W + 1); end
            checks++; if (od !== ed[i]) begin errors++; $display("FAIL dir%0d_diff got=%h exp=%h", i, od, ed[i]); end
            checks++; if (ob !== eb[i]) begin errors++; $display("FAIL dir%0d_bout got=%b exp=%b", i, ob, eb[i]); end
            checks++; if (oo !== eo[i]) begin errors++; $display("FAIL dir%0d_ovf got=%b exp=%b", i, oo, eo[i]); end
            checks++; if (dn !== 1'b0) begin errors++; $display("FAIL dir%0d_done_pulse got=%b exp=0", i, dn); end
            checks++; if (da !== ed[i]) begin errors++; $display("FAIL dir%0d_diff_hold got=%h exp=%h", i, da, ed[i]); end
        end
    endtask

    task automatic test_random();
        int lat; logic [W-1:0] xa, xb, od, da; logic xc, ob, oo, dn;
        for (int i = 0; i < 24; i++) begin
            xa = W'($urandom); xb = W'($urandom); xc = 1'($urandom);
            repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
            do_op(xa, xb, xc, lat, od, ob, oo, dn, da);
            checks++; if (lat !== W + 1) begin errors++; $display("FAIL rnd%0d_latency got=%0d exp=%0d", i, lat, W + 1); end
            checks++; if (od !== ref_diff(xa, xb, xc)) begin errors++; $display("FAIL rnd%0d_diff a=%h b=%h bin=%b got=%h exp=%h", i, xa, xb, xc, od, ref_diff(xa, xb, xc)); end
            checks++; if (ob !== ref_bout(xa, xb, xc)) begin errors++; $display("FAIL rnd%0d_bout a=%h b=%h bin=%b got=%b exp=%b", i, xa, xb, xc, ob, ref_bout(xa, xb, xc)); end
            checks++; if (oo !== ref_ovf(xa, xb, xc)) begin errors++; $display("FAIL rnd%0d_ovf a=%h b=%h bin=%b got=%b exp=%b", i, xa, xb, xc, oo, ref_ovf(xa, xb, xc)); end
            checks++; if (dn !== 1'b0) begin errors++; $display("FAIL rnd%0d_done_pulse got=%b exp=0", i, dn); end
        end
    endtask

    task automatic test_back_to_back();
        int lat; logic [W-1:0] od, da; logic ob, oo, dn;
        logic [W-1:0] xa [3] = '{8'h10, 8'h7F, 8'h00};
        logic [W-1:0] xb [3] = '{8'h20, 8'hFF, 8'h01};
        logic         xc [3] = '{1'b1, 1'b0, 1'b0};
        for (int i = 0; i < 3; i++) begin
            do_op(xa[i], xb[i], xc[i], lat, od, ob, oo, dn, da);
            checks++; if (lat !== W + 1) begin errors++; $display("FAIL b2b%0d_latency got=%0d exp=%0d", i, lat, W + 1); end
            checks++; if (od !== ref_diff(xa[i], xb[i], xc[i])) begin errors++; $display("FAIL b2b%0d_diff got=%h exp=%h", i, od, ref_diff(xa[i], xb[i], xc[i])); end
            checks++; if (oo !== ref_ovf(xa[i], xb[i], xc[i])) begin errors++; $display("FAIL b2b%0d_ovf got=%b exp=%b", i, oo, ref_ovf(xa[i], xb[i], xc[i])); end
        end
    endtask

    task automatic test_ignore_start();
        int ndone = 0; int lat = 0; logic [W-1:0] d1 = '0; logic b1 = 1'b0;
        start = 1'b1; a = 8'h5A; b = 8'h33; bin = 1'b0;
        @(posedge clk); #1;
        start = 1'b0;
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL ign_busy got=%b exp=1", busy); end
        for (int c = 1; c <= 3 * W; c++) begin
            if (c == 3) begin start = 1'b1; a = 8'hC3; b = 8'h0F; bin = 1'b1; end
            else start = 1'b0;
            @(posedge clk); #1;
            if (done === 1'b1) begin
                ndone++;
                if (ndone == 1) begin lat = c + 1; d1 = diff; b1 = bout; end
            end
        end
        start = 1'b0;
        checks++; if (ndone !== 1) begin errors++; $display("FAIL ign_done_count got=%0d exp=1", ndone); end
        checks++; if (lat !== W + 1) begin errors++; $display("FAIL ign_latency got=%0d exp=%0d", lat, W + 1); end
        checks++; if (d1 !== ref_diff(8'h5A, 8'h33, 1'b0)) begin errors++; $display("FAIL ign_diff got=%h exp=%h", d1, ref_diff(8'h5A, 8'h33, 1'b0)); end
        checks++; if (b1 !== ref_bout(8'h5A, 8'h33, 1'b0)) begin errors++; $display("FAIL ign_bout got=%b exp=%b", b1, ref_bout(8'h5A, 8'h33, 1'b0)); end
        checks++; if (diff !== ref_diff(8'h5A, 8'h33, 1'b0)) begin errors++; $display("FAIL ign_diff_hold got=%h exp=%h", diff, ref_diff(8'h5A, 8'h33, 1'b0)); end
    endtask

    task automatic test_reset_mid();
        int ndone = 0; int lat; logic [W-1:0] od, da; logic ob, oo, dn;
        start = 1'b1; a = 8'h01; b = 8'h02; bin = 1'b0;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (3) begin @(posedge clk); #1; end
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rstmid_busy got=%b exp=0", busy); end
        checks++; if (diff !== '0) begin errors++; $display("FAIL rstmid_diff got=%h exp=00", diff); end
        checks++; if (bout !== 1'b0) begin errors++; $display("FAIL rstmid_bout got=%b exp=0", bout); end
        for (int c = 0; c < 2 * W; c++) begin
            if (done === 1'b1) ndone++;
            @(posedge clk); #1;
        end
        checks++; if (ndone !== 0) begin errors++; $display("FAIL rstmid_no_done got=%0d exp=0", ndone); end
        do_op(8'h40, 8'hC0, 1'b0, lat, od, ob, oo, dn, da);
        checks++; if (od !== ref_diff(8'h40, 8'hC0, 1'b0)) begin errors++; $display("FAIL rstmid_after_diff got=%h exp=%h", od, ref_diff(8'h40, 8'hC0, 1'b0)); end
        checks++; if (oo !== ref_ovf(8'h40, 8'hC0, 1'b0)) begin errors++; $display("FAIL rstmid_after_ovf got=%b exp=%b", oo, ref_ovf(8'h40, 8'hC0, 1'b0)); end
    endtask

    task automatic test_ena_stall();
        int lat;
        start = 1'b1; a = 8'hB7; b = 8'h4C; bin = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        lat = 1;
        repeat (3) begin @(posedge clk); #1; lat++; end
        ena = 1'b0;
        repeat (3) begin @(posedge clk); #1; lat++; end
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL stall_busy got=%b exp=1", busy); end
        ena = 1'b1;
        while (done !== 1'b1 && lat < TMO) begin @(posedge clk); #1; lat++; end
        checks++; if (lat !== W + 4) begin errors++; $display("FAIL stall_latency got=%0d exp=%0d", lat, W + 4); end
        checks++; if (diff !== ref_diff(8'hB7, 8'h4C, 1'b1)) begin errors++; $display("FAIL stall_diff got=%h exp=%h", diff, ref_diff(8'hB7, 8'h4C, 1'b1)); end
        checks++; if (ovf !== ref_ovf(8'hB7, 8'h4C, 1'b1)) begin errors++; $display("FAIL stall_ovf got=%b exp=%b", ovf, ref_ovf(8'hB7, 8'h4C, 1'b1)); end
        // Freeze while done is high: the pulse must stretch until ena returns.
        ena = 1'b0;
        repeat (2) begin
            @(posedge clk); #1;
            checks++; if (done !== 1'b1) begin errors++; $display("FAIL stall_done_hold got=%b exp=1", done); end
        end
        ena = 1'b1;
        @(posedge clk); #1;
        checks++; if (done !== 1'b0) begin errors++; $display("FAIL stall_done_end got=%b exp=0", done); end
    endtask

    initial begin
        rst = 1'b1; ena = 1'b1; start = 1'b0; a = '0; b = '0; bin = 1'b0;
        test_reset();
        test_directed();
        test_random();
        test_back_to_back();
        test_ignore_start();
        test_reset_mid();
        test_ena_stall();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
